// File: rtl/i2c_target_regfile.sv
// I2C target at a fixed 7-bit address exposing an 8-bit register file with an
// auto-incrementing pointer, plus a combinational host read port.
module i2c_target_regfile #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned FILTER_LEN  = 3,
    localparam int unsigned PW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    input  logic [PW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRack, StIgnore
    } state_e;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]    sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [CW-1:0] cnt_q [2];

    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_low_q, sda_low_d;
    logic          busy_q, busy_d;
    logic          rw_q, rw_d;
    logic          nack_q, nack_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          reg_we;
    logic [7:0]    rx_byte;
    logic [7:0]    regs_q [NUM_REGS];

    logic scl_f, sda_f, scl_rise, scl_fall, start_cond, stop_cond;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
        end else begin
            sync1_q     <= {sda, scl};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                // Level only moves after FILTER_LEN consecutive differing samples.
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f      = filt_q[0];
    assign sda_f      = filt_q[1];
    assign scl_rise   = filt_q[0] & ~filt_prev_q[0];
    assign scl_fall   = ~filt_q[0] & filt_prev_q[0];
    assign start_cond = ~filt_q[1] & filt_prev_q[1] & scl_f;
    assign stop_cond  = filt_q[1] & ~filt_prev_q[1] & scl_f;
    assign rx_byte    = {shift_q[6:0], sda_f};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_low_d   = sda_low_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        nack_d      = nack_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;
        if (stop_cond) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_cond) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: ;
                StAddr, StPtr, StWdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == StWdata && bit_cnt_q == 4'd7) begin
                            reg_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = rx_byte;
                            ptr_d       = ptr_q + 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == StAddr) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                sda_low_d = 1'b1;
                                busy_d    = 1'b1;
                                rw_d      = shift_q[0];
                                state_d   = StAddrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end else begin
                            sda_low_d = 1'b1;
                            if (state_q == StPtr) begin
                                ptr_d   = shift_q[PW-1:0];
                                state_d = StPtrAck;
                            end else begin
                                state_d = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck, StRack: begin
                    if (state_q == StRack && scl_rise) begin
                        nack_d = sda_f;
                    end else if (scl_fall) begin
                        sda_low_d = 1'b0;
                        if (state_q == StRack && nack_q) begin
                            state_d = StIgnore;
                        end else if ((state_q == StAddrAck && rw_q) || state_q == StRack) begin
                            // Read load: bit 7 goes out on this same fall.
                            sda_low_d = ~regs_q[ptr_q][7];
                            shift_d   = {regs_q[ptr_q][6:0], 1'b0};
                            ptr_d     = ptr_q + 1'b1;
                            bit_cnt_d = 4'd1;
                            state_d   = StRdata;
                        end else if (state_q == StAddrAck) begin
                            state_d = StPtr;
                        end else begin
                            state_d = StWdata;
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            state_d   = StRack;
                        end else begin
                            sda_low_d = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_low_q   <= sda_low_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            nack_q      <= nack_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    assign sda        = sda_low_q ? 1'b0 : 1'bz;
    assign host_rdata = regs_q[host_addr];
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: a bit-banged I2C master drives the target through write,
// read, address-mismatch, wrap, partial-byte, mid-transfer reset and glitch cases.
module tb_i2c_target_regfile;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [3:0] host_addr = '0;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda_bus;

    int tests = 0;
    int fails = 0;
    int pull_cnt = 0;
    int busy_cnt = 0;
    logic [15:0] strobes [$];

    pullup (sda_bus);
    assign sda_bus = sda_m ? 1'bz : 1'b0;

    always #5 clk = ~clk;

    i2c_target_regfile #(
        .TARGET_ADDR(7'h50),
        .NUM_REGS   (16),
        .FILTER_LEN (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda_bus),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (reset && wr_strobe) strobes.push_back({4'h0, wr_addr, wr_data});
        if (sda_m && sda_bus === 1'b0) pull_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quarter();
        repeat (10) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, input logic glitch, output logic s);
        sda_m = b;
        if (glitch) begin
            repeat (3) @(negedge clk);
            scl = 1'b1;
            repeat (2) @(negedge clk);
            scl = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            quarter();
        end
        scl = 1'b1;
        quarter();
        s = sda_bus;
        quarter();
        scl = 1'b0;
        quarter();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; quarter();
        scl = 1'b1;   quarter();
        sda_m = 1'b0; quarter();
        scl = 1'b0;   quarter();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; quarter();
        scl = 1'b1;   quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], gmask[i], s);
        clock_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic ack_m, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clock_bit(ack_m, 1'b0, s);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        #1;
        d = host_rdata;
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] d;
        int         n0, p0, b0;

        repeat (3) @(negedge clk);
        check("reset_sda", {15'h0, sda_bus}, 16'h1);
        check("reset_busy", {15'h0, busy}, 16'h0);
        check("reset_strobe", {15'h0, wr_strobe}, 16'h0);
        check("reset_wr_addr", {12'h0, wr_addr}, 16'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        peek(4'd3, d);
        check("reset_reg3", {8'h0, d}, 16'h0);

        // Pointer write then two data bytes.
        bus_start();
        send_byte(8'hA0, 8'h00, ack); check("w1_addr_ack", {15'h0, ack}, 16'h0);
        check("w1_busy", {15'h0, busy}, 16'h1);
        send_byte(8'h03, 8'h00, ack); check("w1_ptr_ack", {15'h0, ack}, 16'h0);
        send_byte(8'hA5, 8'h00, ack); check("w1_d0_ack", {15'h0, ack}, 16'h0);
        send_byte(8'h3C, 8'h00, ack); check("w1_d1_ack", {15'h0, ack}, 16'h0);
        bus_stop();
        repeat (10) @(negedge clk);
        check("w1_busy_after_stop", {15'h0, busy}, 16'h0);
        check("w1_strobe_count", 16'(strobes.size()), 16'd2);
        if (strobes.size() >= 2) begin
            check("w1_strobe0", strobes[0], 16'h03A5);
            check("w1_strobe1", strobes[1], 16'h043C);
        end
        peek(4'd4, d);
        check("w1_host_reg4", {8'h0, d}, 16'h003C);

        bus_start();
        send_byte(8'hA0, 8'h00, ack);
        send_byte(8'h05, 8'h00, ack);
        send_byte(8'h77, 8'h00, ack); check("w2_d_ack", {15'h0, ack}, 16'h0);
        bus_stop();

        // Pointer write, repeated START, 3-byte read.
        bus_start();
        send_byte(8'hA0, 8'h00, ack);
        send_byte(8'h02, 8'h00, ack);
        bus_start();
        send_byte(8'hA1, 8'h00, ack); check("r1_addr_ack", {15'h0, ack}, 16'h0);
        read_byte(1'b0, d); check("r1_byte0", {8'h0, d}, 16'h0000);
        read_byte(1'b0, d); check("r1_byte1", {8'h0, d}, 16'h00A5);
        read_byte(1'b1, d); check("r1_byte2", {8'h0, d}, 16'h003C);
        bus_stop();
        bus_start();
        send_byte(8'hA1, 8'h00, ack);
        read_byte(1'b1, d); check("r2_ptr_persist", {8'h0, d}, 16'h0077);
        bus_stop();

        // Wrong address.
        n0 = strobes.size(); p0 = pull_cnt; b0 = busy_cnt;
        bus_start();
        send_byte(8'hA2, 8'h00, ack); check("mis_addr_nack", {15'h0, ack}, 16'h1);
        send_byte(8'h12, 8'h00, ack); check("mis_data_nack", {15'h0, ack}, 16'h1);
        bus_stop();
        repeat (10) @(negedge clk);
        check("mis_no_pull", 16'(pull_cnt - p0), 16'd0);
        check("mis_no_strobe", 16'(strobes.size() - n0), 16'd0);
        check("mis_no_busy", 16'(busy_cnt - b0), 16'd0);

        // Pointer wrap and upper pointer bits ignored.
        bus_start();
        send_byte(8'hA0, 8'h00, ack);
        send_byte(8'h0F, 8'h00, ack);
        send_byte(8'h11, 8'h00, ack);
        send_byte(8'h22, 8'h00, ack);
        bus_stop();
        peek(4'd15, d); check("wrap_reg15", {8'h0, d}, 16'h0011);
        peek(4'd0, d);  check("wrap_reg0", {8'h0, d}, 16'h0022);
        bus_start();
        send_byte(8'hA0, 8'h00, ack);
        send_byte(8'h1F, 8'h00, ack);
        send_byte(8'h99, 8'h00, ack);
        bus_stop();
        peek(4'd15, d); check("ptr_mask_reg15", {8'h0, d}, 16'h0099);

        // Partial byte interrupted by STOP.
        bus_start();
        send_byte(8'hA0, 8'h00, ack);
        send_byte(8'h06, 8'h00, ack);
        send_byte(8'h5A, 8'h00, ack);
        bus_stop();
        n0 = strobes.size();
        bus_start();
        send_byte(8'hA0, 8'h00, ack);
        send_byte(8'h06, 8'h00, ack);
        clock_bit(1'b1, 1'b0, s);
        clock_bit(1'b0, 1'b0, s);
        clock_bit(1'b1, 1'b0, s);
        clock_bit(1'b0, 1'b0, s);
        bus_stop();
        check("partial_no_strobe", 16'(strobes.size() - n0), 16'd0);
        bus_start();
        send_byte(8'hA1, 8'h00, ack);
        read_byte(1'b1, d); check("partial_readback", {8'h0, d}, 16'h005A);
        bus_stop();

        // Reset while the target holds SDA low (regs[0]=0x22, bit 7 is 0).
        bus_start();
        send_byte(8'hA0, 8'h00, ack);
        send_byte(8'h00, 8'h00, ack);
        bus_start();
        send_byte(8'hA1, 8'h00, ack);
        check("rst_sda_held_low", {15'h0, sda_bus}, 16'h0);
        reset = 1'b0;
        #1;
        check("rst_sda_released", {15'h0, sda_bus}, 16'h1);
        check("rst_busy", {15'h0, busy}, 16'h0);
        peek(4'd0, d); check("rst_reg0", {8'h0, d}, 16'h0);
        peek(4'd4, d); check("rst_reg4", {8'h0, d}, 16'h0);
        scl = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n0 = strobes.size();
        bus_start();
        send_byte(8'hA0, 8'h00, ack); check("post_rst_ack", {15'h0, ack}, 16'h0);
        send_byte(8'h07, 8'h00, ack);
        send_byte(8'h6B, 8'h00, ack);
        bus_stop();
        peek(4'd7, d); check("post_rst_reg7", {8'h0, d}, 16'h006B);
        if (strobes.size() == n0 + 1) check("post_rst_strobe", strobes[n0], 16'h076B);
        else check("post_rst_strobe_count", 16'(strobes.size() - n0), 16'd1);

        // Short SCL glitch during the address byte.
        bus_start();
        send_byte(8'hA0, 8'h10, ack); check("glitch_addr_ack", {15'h0, ack}, 16'h0);
        send_byte(8'h08, 8'h00, ack);
        send_byte(8'hC3, 8'h00, ack); check("glitch_data_ack", {15'h0, ack}, 16'h0);
        bus_stop();
        peek(4'd8, d); check("glitch_reg8", {8'h0, d}, 16'h00C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
